rsff_pipe: RTL and testbench

- Parametrised multi-bit, multi-stage register pipeline built from set/reset flip-flops.
- Generalises the single-bit techmap RSFF cell in four ways: WIDTH-bit data, DEPTH stages, selectable clock edge, and configurable set/reset values.
- Adds clock enable, synchronous clear, per-stage valid tracking and an occupancy counter.
- Used as the reference model and mapping target for sequential techmap tests with async set/reset.

---
 rtl/rsff_pipe_pkg.sv | 12 +
 rtl/rsff_stage.sv | 69 ++++++
 rtl/rsff_pipe.sv | 87 ++++++++
 tb/tb_rsff_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rsff_pipe_pkg.sv
// Shared constants and helpers for the set/reset flip-flop pipeline.
package rsff_pipe_pkg;

  localparam bit CLK_POS = 1'b0;
  localparam bit CLK_NEG = 1'b1;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rsff_stage.sv
// One pipeline stage: WIDTH-bit RSFF with enable, synchronous clear and a valid tag.
module rsff_stage #(
  parameter int               WIDTH     = 8,
  parameter bit               CLK_NEG   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_in,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic             set_eff;
  logic [WIDTH-1:0] q_nxt;
  logic             vld_nxt;

  // Masking set with reset gives set a rising edge when reset drops while set is
  // still high, so the set state is applied on reset release without a clock.
  assign set_eff = set & ~reset;

  always_comb begin
    q_nxt   = q;
    vld_nxt = vld;
    if (clr) begin
      q_nxt   = RESET_VAL;
      vld_nxt = 1'b0;
    end else if (en) begin
      q_nxt   = d;
      vld_nxt = vld_in;
    end
  end

  generate
    if (CLK_NEG) begin : g_neg
      always_ff @(negedge clk or posedge reset or posedge set_eff) begin
        if (reset) begin
          q   <= RESET_VAL;
          vld <= 1'b0;
        end else if (set_eff) begin
          q   <= SET_VAL;
          vld <= 1'b1;
        end else begin
          q   <= q_nxt;
          vld <= vld_nxt;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk or posedge reset or posedge set_eff) begin
        if (reset) begin
          q   <= RESET_VAL;
          vld <= 1'b0;
        end else if (set_eff) begin
          q   <= SET_VAL;
          vld <= 1'b1;
        end else begin
          q   <= q_nxt;
          vld <= vld_nxt;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rsff_pipe.sv
// DEPTH-stage RSFF shift pipeline with valid tags and an occupancy counter.
module rsff_pipe
  import rsff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter bit               CLK_NEG   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1,
  parameter int               CNT_W     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_in,
  output logic [WIDTH-1:0] q,
  output logic             vld_out,
  output logic [CNT_W-1:0] cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            v;
  logic [CNT_W-1:0]            cnt_nxt;
  logic                        set_eff;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] sd;
      logic             sv;
      if (i == 0) begin : g_head
        assign sd = d;
        assign sv = vld_in;
      end else begin : g_body
        assign sd = data[i-1];
        assign sv = v[i-1];
      end
      rsff_stage #(
        .WIDTH     (WIDTH),
        .CLK_NEG   (CLK_NEG),
        .RESET_VAL (RESET_VAL),
        .SET_VAL   (SET_VAL)
      ) u_stage (
        .clk    (clk),
        .reset  (reset),
        .set    (set),
        .en     (en),
        .clr    (clr),
        .d      (sd),
        .vld_in (sv),
        .q      (data[i]),
        .vld    (v[i])
      );
    end
  endgenerate

  assign q       = data[DEPTH-1];
  assign vld_out = v[DEPTH-1];

  // cnt tracks popcount(v): one tag enters, the tail tag leaves.
  assign set_eff = set & ~reset;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)     cnt_nxt = '0;
    else if (en) cnt_nxt = cnt + CNT_W'(vld_in) - CNT_W'(v[DEPTH-1]);
  end

  generate
    if (CLK_NEG) begin : g_cnt_neg
      always_ff @(negedge clk or posedge reset or posedge set_eff) begin
        if (reset)        cnt <= '0;
        else if (set_eff) cnt <= CNT_W'(DEPTH);
        else              cnt <= cnt_nxt;
      end
    end else begin : g_cnt_pos
      always_ff @(posedge clk or posedge reset or posedge set_eff) begin
        if (reset)        cnt <= '0;
        else if (set_eff) cnt <= CNT_W'(DEPTH);
        else              cnt <= cnt_nxt;
      end
    end
  endgenerate

endmodule

// File: tb/tb_rsff_pipe.sv
// Directed bench: negedge/posedge DEPTH=4, DEPTH=1 WIDTH=1 and DEPTH=7 instances share stimulus.
module tb_rsff_pipe;

  logic       clk = 1'b0;
  logic       reset, set, en, clr, vld_in;
  logic [7:0] d;

  logic [7:0] q_n, q_p, q_7;
  logic       vo_n, vo_p, vo_7, vo_1;
  logic [2:0] cnt_n, cnt_p, cnt_7;
  logic [0:0] q_1, cnt_1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rsff_pipe #(.WIDTH(8), .DEPTH(4), .CLK_NEG(1'b1)) u_n (
    .clk(clk), .reset(reset), .set(set), .en(en), .clr(clr),
    .d(d), .vld_in(vld_in), .q(q_n), .vld_out(vo_n), .cnt(cnt_n));

  rsff_pipe #(.WIDTH(8), .DEPTH(4), .CLK_NEG(1'b0)) u_p (
    .clk(clk), .reset(reset), .set(set), .en(en), .clr(clr),
    .d(d), .vld_in(vld_in), .q(q_p), .vld_out(vo_p), .cnt(cnt_p));

  rsff_pipe #(.WIDTH(1), .DEPTH(1), .CLK_NEG(1'b1)) u_1 (
    .clk(clk), .reset(reset), .set(set), .en(en), .clr(clr),
    .d(d[0]), .vld_in(vld_in), .q(q_1), .vld_out(vo_1), .cnt(cnt_1));

  rsff_pipe #(.WIDTH(8), .DEPTH(7), .CLK_NEG(1'b1)) u_7 (
    .clk(clk), .reset(reset), .set(set), .en(en), .clr(clr),
    .d(d), .vld_in(vld_in), .q(q_7), .vld_out(vo_7), .cnt(cnt_7));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pos_edge();
    @(posedge clk); #1;
  endtask

  task automatic neg_edge();
    @(negedge clk); #1;
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] hd [16];
    logic       hv [16];
    int         e7, e4;

    reset = 1'b1; set = 1'b0; en = 1'b0; clr = 1'b0; vld_in = 1'b0; d = 8'h00;
    neg_edge();
    chk("rst_q_n",   q_n,   8'h00);
    chk("rst_vo_n",  vo_n,  0);
    chk("rst_cnt_n", cnt_n, 0);
    chk("rst_cnt_p", cnt_p, 0);
    chk("rst_cnt_1", cnt_1, 0);
    chk("rst_cnt_7", cnt_7, 0);
    reset = 1'b0;

    // Latency and edge polarity: A1..A4 from empty.
    en = 1'b1; vld_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'hA1 + 8'(k);
      pos_edge();
      chk("lat_cnt_p",      cnt_p, k + 1);
      chk("lat_cnt_n_hold", cnt_n, k);
      neg_edge();
      chk("lat_cnt_n", cnt_n, k + 1);
      chk("lat_vo_n",  vo_n,  (k == 3) ? 1 : 0);
      chk("lat_q_1",   q_1,   (8'hA1 + 8'(k)) & 8'h01);
    end
    chk("lat_q_n",  q_n,  8'hA1);
    chk("lat_q_p",  q_p,  8'hA1);
    chk("lat_vo_p", vo_p, 1);

    // Enable low freezes everything.
    en = 1'b0; d = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      pos_edge(); neg_edge();
      chk("hold_cnt_n", cnt_n, 4);
      chk("hold_q_n",   q_n,   8'hA1);
      chk("hold_cnt_p", cnt_p, 4);
    end

    // Bubbles: vld_in 0,1,0 -> cnt 3,3,2; q walks A2,A3,A4.
    en = 1'b1;
    d = 8'hB0; vld_in = 1'b0; pos_edge(); neg_edge();
    chk("bub0_cnt_n", cnt_n, 3); chk("bub0_q_n", q_n, 8'hA2); chk("bub0_cnt_p", cnt_p, 3);
    d = 8'hB1; vld_in = 1'b1; pos_edge(); neg_edge();
    chk("bub1_cnt_n", cnt_n, 3); chk("bub1_q_n", q_n, 8'hA3);
    d = 8'hB2; vld_in = 1'b0; pos_edge(); neg_edge();
    chk("bub2_cnt_n", cnt_n, 2); chk("bub2_q_n", q_n, 8'hA4); chk("bub2_vo_n", vo_n, 1);
    chk("bub2_cnt_7", cnt_7, 5);

    // Clear beats enable; negedge instance untouched by the posedge.
    clr = 1'b1; vld_in = 1'b1; d = 8'h77;
    pos_edge();
    chk("clr_cnt_p",     cnt_p, 0);
    chk("clr_q_p",       q_p,   8'h00);
    chk("clr_pre_cnt_n", cnt_n, 2);
    chk("clr_pre_q_n",   q_n,   8'hA4);
    neg_edge();
    chk("clr_cnt_n", cnt_n, 0);
    chk("clr_vo_n",  vo_n,  0);
    chk("clr_q_n",   q_n,   8'h00);
    chk("clr_cnt_7", cnt_7, 0);
    clr = 1'b0;

    // DEPTH=7 fill, hold at full, drain; DEPTH=4 and DEPTH=1 ride along.
    for (int k = 0; k < 16; k++) begin
      hd[k] = 8'h10 + 8'(k);
      hv[k] = (k < 9);
      d = hd[k]; vld_in = hv[k];
      neg_edge();
      e7 = 0; e4 = 0;
      for (int j = 0; j <= k; j++) begin
        if (j > k - 7 && hv[j]) e7++;
        if (j > k - 4 && hv[j]) e4++;
      end
      chk("d7_cnt_7", cnt_7, e7);
      chk("d7_cnt_n", cnt_n, e4);
      chk("d7_cnt_1", cnt_1, hv[k]);
      chk("d7_q_1",   q_1,   hd[k] & 8'h01);
      if (k >= 6) begin
        chk("d7_q_7",  q_7,  hd[k-6]);
        chk("d7_vo_7", vo_7, hv[k-6]);
      end else begin
        chk("d7_vo_7", vo_7, 0);
      end
    end

    // Pre-fill, then async reset between edges.
    vld_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'hC0 + 8'(k);
      neg_edge();
    end
    chk("pre_cnt_n", cnt_n, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_q_n",   q_n,   8'h00);
    chk("arst_vo_n",  vo_n,  0);
    chk("arst_cnt_n", cnt_n, 0);
    chk("arst_cnt_7", cnt_7, 0);
    for (int k = 0; k < 3; k++) begin
      neg_edge();
      chk("arst_hold_cnt_n", cnt_n, 0);
      chk("arst_hold_q_n",   q_n,   8'h00);
    end
    reset = 1'b0; #1;
    chk("arst_rel_cnt_n", cnt_n, 0);

    // Async set and its priority against reset.
    set = 1'b1; #1;
    chk("set_q_n",   q_n,   8'hFF);
    chk("set_vo_n",  vo_n,  1);
    chk("set_cnt_n", cnt_n, 4);
    chk("set_cnt_7", cnt_7, 7);
    chk("set_q_1",   q_1,   1);
    reset = 1'b1; #1;
    chk("rs_q_n",   q_n,   8'h00);
    chk("rs_cnt_n", cnt_n, 0);
    reset = 1'b0; #1;
    chk("rs_rel_q_n",   q_n,   8'hFF);
    chk("rs_rel_cnt_n", cnt_n, 4);
    chk("rs_rel_cnt_p", cnt_p, 4);
    d = 8'h33; vld_in = 1'b0;
    neg_edge();
    chk("set_hold_q_n",   q_n,   8'hFF);
    chk("set_hold_cnt_n", cnt_n, 4);
    set = 1'b0; #1;
    chk("set_rel_cnt_n", cnt_n, 4);
    chk("set_rel_vo_n",  vo_n,  1);
    neg_edge();
    chk("post_set_cnt_n", cnt_n, 3);
    chk("post_set_q_n",   q_n,   8'hFF);
    chk("post_set_q_1",   q_1,   1);
    chk("post_set_cnt_1", cnt_1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
